// File: rtl/fetch_queue.sv
// Fetch front end: PC generation, synchronous ROM reads and a DEPTH-entry {pc, instr} queue
// feeding decode over valid/ready. Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when empty.
module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       jflag_in,
   input  logic [XLEN-1:0]            jaddr_in,
   output logic                       rom_re_out,
   output logic [XLEN-1:0]            rom_addr_out,
   input  logic [XLEN-1:0]            rom_data_in,
   output logic                       id_valid_out,
   input  logic                       id_ready_in,
   output logic [XLEN-1:0]            id_data_out,
   output logic [XLEN-1:0]            id_pc_out,
   output logic [$clog2(DEPTH):0]     count_out
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

   logic [XLEN-1:0] pc_reg;
   logic [XLEN-1:0] req_pc_reg;
   logic            pending_reg;
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];

   logic [CW:0]     credit;
   logic            issue;
   logic            resp;
   logic            fifo_empty;
   logic            head_valid;
   logic            bypass_take;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] head_pc;
   logic [XLEN-1:0] head_instr;

   // Occupancy plus the one read in flight must leave room, so a response can always be written.
   assign credit     = {1'b0, count_reg} + {{CW{1'b0}}, pending_reg};
   assign issue      = rst && (credit < (CW+1)'(DEPTH)) && !jflag_in;
   assign resp       = pending_reg && !jflag_in;
   assign fifo_empty = (count_reg == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
   assign head_valid  = !fifo_empty || resp;
   assign head_pc     = fifo_empty ? req_pc_reg  : pc_mem[rd_ptr_reg];
   assign head_instr  = fifo_empty ? rom_data_in : instr_mem[rd_ptr_reg];
   assign bypass_take = fifo_empty && resp && id_ready_in;
`else
   assign head_valid  = !fifo_empty;
   assign head_pc     = pc_mem[rd_ptr_reg];
   assign head_instr  = instr_mem[rd_ptr_reg];
   assign bypass_take = 1'b0;
`endif

   assign push = resp && !bypass_take;
   assign pop  = !fifo_empty && id_ready_in && !jflag_in;

   assign rom_re_out   = issue;
   assign rom_addr_out = pc_reg;
   assign id_valid_out = head_valid;
   assign id_data_out  = head_valid ? head_instr : NOP;
   assign id_pc_out    = head_valid ? head_pc : '0;
   assign count_out    = count_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_reg      <= RESET_PC;
         req_pc_reg  <= '0;
         pending_reg <= 1'b0;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
      end else begin
         pending_reg <= issue;
         if (issue) begin
            req_pc_reg <= pc_reg;
            pc_reg     <= pc_reg + XLEN'(4);
         end
         if (jflag_in) begin
            // Misaligned targets are silently aligned down.
            pc_reg     <= jaddr_in & ~XLEN'(3);
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
               2'b10:   count_reg <= count_reg + CW'(1);
               2'b01:   count_reg <= count_reg - CW'(1);
               default: count_reg <= count_reg;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_reg]    <= req_pc_reg;
         instr_mem[wr_ptr_reg] <= rom_data_in;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a ROM model plus a scoreboard of expected head PCs,
// with one task per scenario. Honors FETCH_QUEUE_BYPASS_EN for the latency expectations.
module tb_fetch_queue;
   localparam logic [31:0] MAGIC = 32'h0010_0093;
   localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        jflag_in = 1'b0;
   logic [31:0] jaddr_in = '0;
   logic        rom_re_out;
   logic [31:0] rom_addr_out;
   logic [31:0] rom_data_in = '0;
   logic        id_valid_out;
   logic        id_ready_in = 1'b0;
   logic [31:0] id_data_out;
   logic [31:0] id_pc_out;
   logic [2:0]  count_out;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   fetch_queue dut (
      .clk          (clk),
      .rst          (rst),
      .jflag_in     (jflag_in),
      .jaddr_in     (jaddr_in),
      .rom_re_out   (rom_re_out),
      .rom_addr_out (rom_addr_out),
      .rom_data_in  (rom_data_in),
      .id_valid_out (id_valid_out),
      .id_ready_in  (id_ready_in),
      .id_data_out  (id_data_out),
      .id_pc_out    (id_pc_out),
      .count_out    (count_out)
   );

   always #5 clk = ~clk;

   // ROM: word at address A is A + MAGIC, one cycle after the read.
   always @(posedge clk) begin
      if (rom_re_out) rom_data_in <= rom_addr_out + MAGIC;
   end

   // Scoreboard consumer: every accepted head must match the next expected PC.
   always @(negedge clk) begin
      if (rst && id_valid_out && id_ready_in && !jflag_in) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL head_order: got pc %h, expected none", id_pc_out);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (id_pc_out !== e || id_data_out !== e + MAGIC) begin
               errors++;
               $display("FAIL head_order: got pc %h data %h, expected pc %h data %h",
                        id_pc_out, id_data_out, e, e + MAGIC);
            end else
               $display("head pc %h data %h ok", id_pc_out, id_data_out);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic load_exp(input logic [31:0] base);
      exp_q.delete();
      for (int i = 0; i < 128; i++) exp_q.push_back(base + 32'(4 * i));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      jflag_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      load_exp(32'h0);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      id_ready_in = 1'b1;
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (id_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", id_valid_out); end
      checks++; if (rom_re_out !== 1'b0) begin errors++; $display("FAIL rst_re: got %b expected 0", rom_re_out); end
      checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count_out); end
      checks++; if (id_data_out !== NOP) begin errors++; $display("FAIL rst_data: got %h expected %h", id_data_out, NOP); end
      checks++; if (id_pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", id_pc_out); end
      tick();
      load_exp(32'h0);
      rst = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k <= 3) begin
            checks++;
            if (rom_re_out !== 1'b1 || rom_addr_out !== 32'(4 * (k - 1))) begin
               errors++;
               $display("FAIL reset_issue: cycle %0d got re %b addr %h expected re 1 addr %h",
                        k, rom_re_out, rom_addr_out, 32'(4 * (k - 1)));
            end
         end
         checks++;
         if (k < 3 - BYP) begin
            if (id_valid_out !== 1'b0) begin errors++; $display("FAIL reset_latency: cycle %0d got valid %b expected 0", k, id_valid_out); end
         end else if (k == 3 - BYP) begin
            if (id_valid_out !== 1'b1 || id_pc_out !== 32'h0 || id_data_out !== MAGIC) begin
               errors++;
               $display("FAIL reset_first: got valid %b pc %h data %h expected 1 0 %h",
                        id_valid_out, id_pc_out, id_data_out, MAGIC);
            end
         end else begin
            if (id_valid_out !== 1'b1) begin errors++; $display("FAIL throughput: cycle %0d got valid %b expected 1", k, id_valid_out); end
         end
         tick();
      end
   endtask

   task automatic test_stall();
      int exp_cnt[10] = '{0, 0, 1, 2, 3, 4, 4, 4, 4, 4};
      id_ready_in = 1'b0;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         if (k == 11) id_ready_in = 1'b1;
         @(negedge clk);
         if (k <= 10) begin
            checks++;
            if (count_out !== 3'(exp_cnt[k-1])) begin errors++; $display("FAIL stall_count: cycle %0d got %0d expected %0d", k, count_out, exp_cnt[k-1]); end
            checks++;
            if (rom_re_out !== (k <= 4)) begin errors++; $display("FAIL stall_re: cycle %0d got %b expected %b", k, rom_re_out, (k <= 4)); end
         end else begin
            checks++;
            if (id_valid_out !== 1'b1) begin errors++; $display("FAIL stall_drain: cycle %0d got valid %b expected 1", k, id_valid_out); end
         end
         if (k == 10 || k == 11) begin
            checks++;
            if (rom_addr_out !== 32'h10 || rom_re_out !== 1'b0) begin errors++; $display("FAIL stall_pc: cycle %0d got addr %h re %b expected 10 0", k, rom_addr_out, rom_re_out); end
         end
         if (k == 12) begin
            checks++;
            if (rom_addr_out !== 32'h10 || rom_re_out !== 1'b1) begin errors++; $display("FAIL stall_resume: got addr %h re %b expected 10 1", rom_addr_out, rom_re_out); end
         end
         tick();
      end
   endtask

   task automatic test_redirect_full();
      id_ready_in = 1'b0;
      do_reset();
      repeat (7) tick();
      @(negedge clk);
      checks++; if (count_out !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count_out); end
      tick();
      jflag_in = 1'b1; jaddr_in = 32'h200;
      load_exp(32'h200);
      @(negedge clk);
      checks++; if (rom_re_out !== 1'b0) begin errors++; $display("FAIL full_jump_re: got %b expected 0", rom_re_out); end
      tick();
      jflag_in = 1'b0; id_ready_in = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
         if (j == 1) begin
            checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL full_flush: got count %0d expected 0", count_out); end
            checks++; if (rom_re_out !== 1'b1 || rom_addr_out !== 32'h200) begin errors++; $display("FAIL full_target: got re %b addr %h expected 1 200", rom_re_out, rom_addr_out); end
         end
         checks++;
         if (j < 3 - BYP) begin
            if (id_valid_out !== 1'b0) begin errors++; $display("FAIL full_latency: N+%0d got valid %b expected 0", j, id_valid_out); end
         end else if (j == 3 - BYP) begin
            if (id_valid_out !== 1'b1 || id_pc_out !== 32'h200) begin errors++; $display("FAIL full_head: got valid %b pc %h expected 1 200", id_valid_out, id_pc_out); end
         end else begin
            if (id_valid_out !== 1'b1) begin errors++; $display("FAIL full_stream: N+%0d got valid %b expected 1", j, id_valid_out); end
         end
         tick();
      end
   endtask

   task automatic test_redirect_response();
      id_ready_in = 1'b1;
      do_reset();
      repeat (4) tick();
      jflag_in = 1'b1; jaddr_in = 32'h80;
      load_exp(32'h80);
      @(negedge clk);
      checks++; if (rom_re_out !== 1'b0) begin errors++; $display("FAIL resp_jump_re: got %b expected 0", rom_re_out); end
      tick();
      jflag_in = 1'b0;
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
         if (j == 1) begin
            checks++; if (rom_re_out !== 1'b1 || rom_addr_out !== 32'h80) begin errors++; $display("FAIL resp_target: got re %b addr %h expected 1 80", rom_re_out, rom_addr_out); end
         end
         if (j == 3 - BYP || j == 4 - BYP) begin
            checks++;
            if (id_valid_out !== 1'b1 || id_pc_out !== ((j == 3 - BYP) ? 32'h80 : 32'h84)) begin
               errors++;
               $display("FAIL resp_head: N+%0d got valid %b pc %h expected 1 %h", j, id_valid_out, id_pc_out,
                        (j == 3 - BYP) ? 32'h80 : 32'h84);
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      id_ready_in = 1'b1;
      do_reset();
      repeat (4) tick();
      jflag_in = 1'b1; jaddr_in = 32'h100;
      load_exp(32'h300);
      for (int j = 0; j <= 8; j++) begin
         if (j == 1) jaddr_in = 32'h300;
         if (j == 2) jflag_in = 1'b0;
         @(negedge clk);
         checks++;
         if (rom_re_out === 1'b1 && rom_addr_out === 32'h100) begin errors++; $display("FAIL b2b_stale: N+%0d got issue of 100 expected none", j); end
         if (j == 2) begin
            checks++; if (rom_re_out !== 1'b1 || rom_addr_out !== 32'h300) begin errors++; $display("FAIL b2b_target: got re %b addr %h expected 1 300", rom_re_out, rom_addr_out); end
         end
         if (j == 4 - BYP) begin
            checks++; if (id_valid_out !== 1'b1 || id_pc_out !== 32'h300) begin errors++; $display("FAIL b2b_head: got valid %b pc %h expected 1 300", id_valid_out, id_pc_out); end
         end
         tick();
      end
   endtask

   task automatic test_misalign_reset();
      id_ready_in = 1'b1;
      do_reset();
      repeat (3) tick();
      jflag_in = 1'b1; jaddr_in = 32'h103;
      load_exp(32'h100);
      tick();
      jflag_in = 1'b0;
      @(negedge clk);
      checks++; if (rom_re_out !== 1'b1 || rom_addr_out !== 32'h100) begin errors++; $display("FAIL misalign: got re %b addr %h expected 1 100", rom_re_out, rom_addr_out); end
      repeat (6) tick();
      #2 rst = 1'b0;
      #1;
      checks++; if (id_valid_out !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", id_valid_out); end
      checks++; if (rom_re_out !== 1'b0) begin errors++; $display("FAIL async_re: got %b expected 0", rom_re_out); end
      checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL async_count: got %0d expected 0", count_out); end
      checks++; if (id_pc_out !== 32'h0 || id_data_out !== NOP) begin errors++; $display("FAIL async_head: got pc %h data %h expected 0 %h", id_pc_out, id_data_out, NOP); end
      checks++; if (rom_addr_out !== 32'h0) begin errors++; $display("FAIL async_pc: got %h expected 0", rom_addr_out); end
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      load_exp(32'h0);
      rst = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checks++; if (rom_re_out !== 1'b1 || rom_addr_out !== 32'h0) begin errors++; $display("FAIL restart: got re %b addr %h expected 1 0", rom_re_out, rom_addr_out); end
         end
         if (k == 3 - BYP) begin
            checks++; if (id_valid_out !== 1'b1 || id_pc_out !== 32'h0) begin errors++; $display("FAIL restart_head: got valid %b pc %h expected 1 0", id_valid_out, id_pc_out); end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_stall();
      test_redirect_full();
      test_redirect_response();
      test_back_to_back();
      test_misalign_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
